// File: rtl/ppu_pkg.sv
// Shared PPU sizing helpers and the multiply-core state encoding.
// Exponent and mantissa widths are derived from the posit width N.
package ppu_pkg;

  localparam int ES = 2;

  function automatic int mant_size_f(input int n);
    return n - 2;
  endfunction

  function automatic int te_size_f(input int n);
    return $clog2(n) + ES + 1;
  endfunction

  function automatic int mul_result_size_f(input int n);
    return 2 * mant_size_f(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/core_mul_seq_if.sv
// Operand/result handshake bundle for core_mul_seq.
// The master drives operands and accepts results; the slave is the core.
interface core_mul_seq_if
  import ppu_pkg::*;
#(
  parameter int N = 16
);
  localparam int M  = mant_size_f(N);
  localparam int TE = te_size_f(N);
  localparam int P  = mul_result_size_f(N);

  logic          in_valid;
  logic          in_ready;
  logic [TE-1:0] te1;
  logic [TE-1:0] te2;
  logic [M-1:0]  mant1;
  logic [M-1:0]  mant2;
  logic          out_valid;
  logic          out_ready;
  logic [P-1:0]  mant_out;
  logic [TE-1:0] te_out;

  modport master (
    output in_valid, te1, te2, mant1, mant2, out_ready,
    input  in_ready, out_valid, mant_out, te_out
  );

  modport slave (
    input  in_valid, te1, te2, mant1, mant2, out_ready,
    output in_ready, out_valid, mant_out, te_out
  );
endinterface

// File: rtl/shift_add_mult.sv
// Radix-2 shift-add mantissa multiplier, one partial product per step.
// prod_o is the accumulator value after the current step; last_o flags the final step.
module shift_add_mult #(
  parameter int M = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic           step_i,
  input  logic [M-1:0]   mant_a_i,
  input  logic [M-1:0]   mant_b_i,
  output logic [2*M-1:0] prod_o,
  output logic           last_o
);
  localparam int CW = $clog2(M + 1);

  logic [2*M-1:0] acc_q;
  logic [2*M-1:0] acc_d;
  logic [M-1:0]   mult_q;
  logic [M-1:0]   mcand_q;
  logic [CW-1:0]  cnt_q;

  // Partial product is widened before shifting so no high bits are lost.
  always_comb begin
    acc_d = acc_q;
    if (mult_q[0]) begin
      acc_d = acc_q + ({{M{1'b0}}, mcand_q} << cnt_q);
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mult_q  <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
    end else if (start_i) begin
      acc_q   <= '0;
      mult_q  <= mant_a_i;
      mcand_q <= mant_b_i;
      cnt_q   <= '0;
    end else if (step_i) begin
      acc_q  <= acc_d;
      mult_q <= mult_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
    end
  end

  assign prod_o = acc_d;
  assign last_o = step_i && (cnt_q == CW'(M - 1));
endmodule

// File: rtl/core_mul_seq.sv
// Sequential te/mantissa multiply core: accept, MANT_SIZE shift-add steps, normalize, hold until taken.
// Only in_ready depends combinationally on an input (out_ready), enabling back-to-back operations.
module core_mul_seq
  import ppu_pkg::*;
#(
  parameter int N = 16
) (
  input logic           clk,
  input logic           rst_n,
  core_mul_seq_if.slave bus
);
  localparam int M  = mant_size_f(N);
  localparam int TE = te_size_f(N);
  localparam int P  = mul_result_size_f(N);

  state_e        state_q;
  state_e        state_d;
  logic [TE-1:0] te_sum_q;
  logic          out_valid_q;
  logic [P-1:0]  mant_out_q;
  logic [TE-1:0] te_out_q;
  logic [P-1:0]  prod_s;
  logic [P-1:0]  mant_norm_s;
  logic [TE-1:0] te_norm_s;
  logic          in_ready_s;
  logic          accept_s;
  logic          step_s;
  logic          handshake_s;
  logic          last_s;

  shift_add_mult #(.M(M)) u_mult (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept_s),
    .step_i   (step_s),
    .mant_a_i (bus.mant1),
    .mant_b_i (bus.mant2),
    .prod_o   (prod_s),
    .last_o   (last_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) state_d = BUSY;
        else              state_d = IDLE;
      end
      BUSY: begin
        if (last_s) state_d = DONE;
        else        state_d = BUSY;
      end
      DONE: begin
        if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
        else               state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_s  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    accept_s    = bus.in_valid && in_ready_s;
    step_s      = (state_q == BUSY);
    handshake_s = (state_q == DONE) && bus.out_ready;
  end

  // Product lies in [1,4): a clear MSB means one left shift restores the hidden one.
  always_comb begin
    mant_norm_s = prod_s;
    te_norm_s   = te_sum_q;
    if (prod_s[P-1]) begin
      mant_norm_s = prod_s;
      te_norm_s   = te_sum_q + TE'(1);
    end else begin
      mant_norm_s = prod_s << 1;
      te_norm_s   = te_sum_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      te_sum_q    <= '0;
      out_valid_q <= 1'b0;
      mant_out_q  <= '0;
      te_out_q    <= '0;
    end else begin
      if (accept_s) begin
        te_sum_q <= bus.te1 + bus.te2;
      end
      if (last_s) begin
        out_valid_q <= 1'b1;
        mant_out_q  <= mant_norm_s;
        te_out_q    <= te_norm_s;
      end else if (handshake_s) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.mant_out  = mant_out_q;
  assign bus.te_out    = te_out_q;
endmodule

// File: tb/tb_core_mul_seq.sv
// Directed-vector bench for core_mul_seq at N=16 (14-bit mantissas, 7-bit exponents).
module tb_core_mul_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  core_mul_seq_if #(.N(16)) bus ();

  core_mul_seq #(.N(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits up to 40 edges for out_valid, returning the number of edges taken.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [13:0] m1, input logic [13:0] m2,
                        input logic [6:0] t1, input logic [6:0] t2,
                        input logic [27:0] em, input logic [6:0] et);
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant1 = m1; bus.mant2 = m2; bus.te1 = t1; bus.te2 = t2;
    bus.out_ready = 1'b1;
    check_val({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.mant1 = 14'h1555; bus.mant2 = 14'h2AAA; bus.te1 = 7'h55; bus.te2 = 7'h2A;
    check_val({tag, "_busy_rdy"}, 32'(bus.in_ready), 32'd0);
    wait_result(lat);
    check_val({tag, "_latency"}, 32'(lat), 32'd14);
    check_val({tag, "_mant"}, 32'(bus.mant_out), 32'(em));
    check_val({tag, "_te"}, 32'(bus.te_out), 32'(et));
    @(posedge clk); #1;
    check_val({tag, "_vld_drop"}, 32'(bus.out_valid), 32'd0);
    check_val({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int spurious;
    logic [27:0] held_mant;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.mant1 = '0; bus.mant2 = '0; bus.te1 = '0; bus.te2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_mant", 32'(bus.mant_out), 32'd0);
    check_val("rst_te", 32'(bus.te_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_val("rst_ready", 32'(bus.in_ready), 32'd1);

    run_op("one_x_one", 14'h2000, 14'h2000, 7'd0, 7'd0, 28'h8000000, 7'h00);
    run_op("1p5_x_1p5", 14'h3000, 14'h3000, 7'd3, 7'h7B, 28'h9000000, 7'h7F);
    run_op("max_mant", 14'h3FFF, 14'h3FFF, 7'd0, 7'd0, 28'hFFF8001, 7'h01);
    run_op("te_wrap", 14'h3000, 14'h3000, 7'd63, 7'd0, 28'h9000000, 7'h40);

    // Backpressure then back-to-back accept on the releasing edge.
    @(negedge clk);
    bus.out_ready = 1'b0; bus.in_valid = 1'b1;
    bus.mant1 = 14'h3000; bus.mant2 = 14'h3000; bus.te1 = 7'd3; bus.te2 = 7'h7B;
    @(posedge clk); #1;
    bus.mant1 = 14'h2000; bus.mant2 = 14'h2000; bus.te1 = 7'd2; bus.te2 = 7'd1;
    wait_result(lat);
    check_val("bp_latency", 32'(lat), 32'd14);
    check_val("bp_mant", 32'(bus.mant_out), 32'h9000000);
    held_mant = bus.mant_out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_val("bp_hold_vld", 32'(bus.out_valid), 32'd1);
      check_val("bp_hold_mant", 32'(bus.mant_out), 32'(held_mant));
      check_val("bp_hold_te", 32'(bus.te_out), 32'h7F);
      check_val("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check_val("b2b_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_val("b2b_vld_drop", 32'(bus.out_valid), 32'd0);
    wait_result(lat);
    check_val("b2b_latency", 32'(lat), 32'd14);
    check_val("b2b_mant", 32'(bus.mant_out), 32'h8000000);
    check_val("b2b_te", 32'(bus.te_out), 32'h03);
    @(posedge clk); #1;

    // Reset in the middle of BUSY discards the operation.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.mant1 = 14'h3FFF; bus.mant2 = 14'h3FFF; bus.te1 = 7'd5; bus.te2 = 7'd5;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_vld", 32'(bus.out_valid), 32'd0);
    check_val("mid_rst_mant", 32'(bus.mant_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_val("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
    spurious = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) spurious++;
    end
    check_val("mid_rst_no_out", 32'(spurious), 32'd0);
    run_op("post_rst", 14'h3000, 14'h2000, 7'd1, 7'd2, 28'hC000000, 7'h03);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
